// File: rtl/alu_control_seq.sv
// Registered ALU control decoder with a handshaked issue port and a
// multi-cycle mul/div sequencer that holds off issue while HI/LO is busy.
module alu_control_seq #(
  parameter int CTRL_W  = 4,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 8,
  parameter int CNT_W   = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        ALUOp,
  input  logic [5:0]        funct,
  output logic              out_valid,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic              PCregs,
  output logic              illegal,
  output logic              md_start,
  output logic              md_busy,
  output logic              md_done,
  output logic [1:0]        hilo_sel
);

  // state | meaning
  // IDLE  | accepting; decodes of accepted ops appear next cycle
  // BUSY  | mul/div in flight; cnt counts remaining busy cycles down to 1
  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic [3:0] d_ctrl;
  logic       d_pc;
  logic       d_ill;
  logic       d_md;
  logic       d_div;
  logic [1:0] d_hilo;
  logic       accept;

  always_comb begin
    d_ctrl = 4'b0000;
    d_pc   = 1'b0;
    d_ill  = 1'b0;
    d_md   = 1'b0;
    d_div  = 1'b0;
    d_hilo = 2'b00;
    unique case (ALUOp)
      4'b0001:          d_ctrl = 4'b0001;
      4'b0010:          d_ctrl = 4'b1010;
      4'b0011:          d_ctrl = 4'b1011;
      4'b0100:          d_ctrl = 4'b1100;
      4'b0101, 4'b0110: d_ctrl = 4'b0010;
      4'b0111, 4'b1000: d_ctrl = 4'b0111;
      4'b1001:          d_ctrl = 4'b0000;
      4'b1010, 4'b1011: d_ctrl = 4'b0001;
      4'b1100, 4'b1101: d_ctrl = 4'b0000;
      4'b1111: begin
        unique case (funct)
          6'd32:        d_ctrl = 4'b0001;
          6'd34:        d_ctrl = 4'b0010;
          6'd36:        d_ctrl = 4'b1010;
          6'd37:        d_ctrl = 4'b1011;
          6'd38:        d_ctrl = 4'b1100;
          6'd39:        d_ctrl = 4'b1101;
          6'd42, 6'd43: d_ctrl = 4'b0111;
          6'd0:         d_ctrl = 4'b0011;
          6'd2:         d_ctrl = 4'b0100;
          6'd3:         d_ctrl = 4'b0110;
          6'd8:         d_pc   = 1'b1;
          6'd16:        d_hilo = 2'b01;
          6'd18:        d_hilo = 2'b10;
          6'd24, 6'd25: begin
            d_ctrl = 4'b1000;
            d_md   = 1'b1;
          end
          6'd26, 6'd27: begin
            d_ctrl = 4'b1001;
            d_md   = 1'b1;
            d_div  = 1'b1;
          end
          default:      d_ill  = 1'b1;
        endcase
      end
      default:          d_ill  = 1'b1;
    endcase
  end

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;
  assign md_busy  = (state == BUSY);
  assign md_done  = md_busy && (cnt == CNT_W'(1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      alu_ctrl  <= '0;
      PCregs    <= 1'b0;
      illegal   <= 1'b0;
      md_start  <= 1'b0;
      hilo_sel  <= 2'b00;
    end else begin
      out_valid <= accept;
      md_start  <= accept && d_md;
      if (accept) begin
        alu_ctrl <= CTRL_W'(d_ctrl);
        PCregs   <= d_pc;
        illegal  <= d_ill;
        hilo_sel <= d_hilo;
      end
      unique case (state)
        IDLE: begin
          if (accept && d_md) begin
            state <= BUSY;
            cnt   <= d_div ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
          end
        end
        BUSY: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt <= CNT_W'(1)) begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_control_seq.sv
// Directed bench for alu_control_seq: table of single-cycle decodes plus
// hand-written mul/div busy, hazard and reset-abort sequences.
module tb_alu_control_seq;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] ALUOp;
  logic [5:0] funct;
  logic       out_valid;
  logic [3:0] alu_ctrl;
  logic       PCregs;
  logic       illegal;
  logic       md_start;
  logic       md_busy;
  logic       md_done;
  logic [1:0] hilo_sel;

  alu_control_seq #(.CTRL_W(4), .MUL_LAT(4), .DIV_LAT(8), .CNT_W(4)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .ALUOp(ALUOp), .funct(funct), .out_valid(out_valid), .alu_ctrl(alu_ctrl),
    .PCregs(PCregs), .illegal(illegal), .md_start(md_start), .md_busy(md_busy),
    .md_done(md_done), .hilo_sel(hilo_sel)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] op;
    logic [5:0] fn;
    logic [3:0] ctrl;
    logic       pc;
    logic       ill;
    logic [1:0] hilo;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic add(input logic [3:0] op, input logic [5:0] fn, input logic [3:0] ctrl,
                     input logic pc, input logic ill, input logic [1:0] hilo);
    vec_t v;
    v.op = op; v.fn = fn; v.ctrl = ctrl; v.pc = pc; v.ill = ill; v.hilo = hilo;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " out_valid"}, 32'(out_valid), 0);
    check({tag, " alu_ctrl"},  32'(alu_ctrl),  0);
    check({tag, " PCregs"},    32'(PCregs),    0);
    check({tag, " illegal"},   32'(illegal),   0);
    check({tag, " md_start"},  32'(md_start),  0);
    check({tag, " md_busy"},   32'(md_busy),   0);
    check({tag, " md_done"},   32'(md_done),   0);
    check({tag, " hilo_sel"},  32'(hilo_sel),  0);
    check({tag, " in_ready"},  32'(in_ready),  1);
  endtask

  initial begin
    add(4'b0001, 6'd0,  4'b0001, 0, 0, 2'b00);
    add(4'b0010, 6'd0,  4'b1010, 0, 0, 2'b00);
    add(4'b0011, 6'd0,  4'b1011, 0, 0, 2'b00);
    add(4'b0100, 6'd0,  4'b1100, 0, 0, 2'b00);
    add(4'b0000, 6'd0,  4'b0000, 0, 1, 2'b00);
    add(4'b0101, 6'd0,  4'b0010, 0, 0, 2'b00);
    add(4'b0110, 6'd0,  4'b0010, 0, 0, 2'b00);
    add(4'b0111, 6'd0,  4'b0111, 0, 0, 2'b00);
    add(4'b1000, 6'd0,  4'b0111, 0, 0, 2'b00);
    add(4'b1001, 6'd0,  4'b0000, 0, 0, 2'b00);
    add(4'b1010, 6'd0,  4'b0001, 0, 0, 2'b00);
    add(4'b1011, 6'd0,  4'b0001, 0, 0, 2'b00);
    add(4'b1100, 6'd0,  4'b0000, 0, 0, 2'b00);
    add(4'b1101, 6'd0,  4'b0000, 0, 0, 2'b00);
    add(4'b1111, 6'd34, 4'b0010, 0, 0, 2'b00);
    add(4'b1111, 6'd8,  4'b0000, 1, 0, 2'b00);
    add(4'b1111, 6'd32, 4'b0001, 0, 0, 2'b00);
    add(4'b1110, 6'd32, 4'b0000, 0, 1, 2'b00);
    add(4'b1111, 6'd36, 4'b1010, 0, 0, 2'b00);
    add(4'b1111, 6'd37, 4'b1011, 0, 0, 2'b00);
    add(4'b1111, 6'd38, 4'b1100, 0, 0, 2'b00);
    add(4'b1111, 6'd1,  4'b0000, 0, 1, 2'b00);
    add(4'b1111, 6'd39, 4'b1101, 0, 0, 2'b00);
    add(4'b1111, 6'd42, 4'b0111, 0, 0, 2'b00);
    add(4'b1111, 6'd43, 4'b0111, 0, 0, 2'b00);
    add(4'b1111, 6'd0,  4'b0011, 0, 0, 2'b00);
    add(4'b1111, 6'd2,  4'b0100, 0, 0, 2'b00);
    add(4'b1111, 6'd3,  4'b0110, 0, 0, 2'b00);
    add(4'b1111, 6'd16, 4'b0000, 0, 0, 2'b01);
    add(4'b1111, 6'd18, 4'b0000, 0, 0, 2'b10);
    add(4'b1111, 6'd63, 4'b0000, 0, 1, 2'b00);
    add(4'b1111, 6'd37, 4'b1011, 0, 0, 2'b00);

    reset_n = 1'b0; in_valid = 1'b0; ALUOp = 4'b0; funct = 6'd0;
    #3;
    check_idle_outputs("reset");
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // load a nonzero code, then reset mid-run and confirm everything clears
    in_valid = 1'b1; ALUOp = 4'b0010;
    tick();
    in_valid = 1'b0;
    check("pre-reset alu_ctrl", 32'(alu_ctrl), 32'hA);
    #2 reset_n = 1'b0;
    #1 check_idle_outputs("midrun reset");
    tick();
    reset_n = 1'b1;
    tick();
    in_valid = 1'b1; ALUOp = 4'b0001;
    tick();
    in_valid = 1'b0;
    check("post-reset out_valid", 32'(out_valid), 1);
    check("post-reset alu_ctrl", 32'(alu_ctrl), 32'h1);
    tick();

    // back-to-back decode table
    for (int i = 0; i < tbl.size(); i++) begin
      in_valid = 1'b1; ALUOp = tbl[i].op; funct = tbl[i].fn;
      tick();
      check($sformatf("vec%0d out_valid", i), 32'(out_valid), 1);
      check($sformatf("vec%0d alu_ctrl", i),  32'(alu_ctrl),  32'(tbl[i].ctrl));
      check($sformatf("vec%0d PCregs", i),    32'(PCregs),    32'(tbl[i].pc));
      check($sformatf("vec%0d illegal", i),   32'(illegal),   32'(tbl[i].ill));
      check($sformatf("vec%0d md_start", i),  32'(md_start),  0);
      check($sformatf("vec%0d hilo_sel", i),  32'(hilo_sel),  32'(tbl[i].hilo));
      check($sformatf("vec%0d in_ready", i),  32'(in_ready),  1);
    end
    in_valid = 1'b0;
    tick();
    check("gap out_valid", 32'(out_valid), 0);
    check("gap alu_ctrl hold", 32'(alu_ctrl), 32'hB);

    // MULT: busy T+1..T+4, done only at T+4, ready again at T+5
    in_valid = 1'b1; ALUOp = 4'b1111; funct = 6'd24;
    tick();
    in_valid = 1'b0;
    check("mult md_start", 32'(md_start), 1);
    check("mult alu_ctrl", 32'(alu_ctrl), 32'h8);
    check("mult out_valid", 32'(out_valid), 1);
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) tick();
      check($sformatf("mult T+%0d md_busy", k),  32'(md_busy),  1);
      check($sformatf("mult T+%0d in_ready", k), 32'(in_ready), 0);
      check($sformatf("mult T+%0d md_done", k),  32'(md_done),  (k == 4) ? 1 : 0);
      if (k > 1) check($sformatf("mult T+%0d md_start", k), 32'(md_start), 0);
    end
    tick();
    check("mult T+5 in_ready", 32'(in_ready), 1);
    check("mult T+5 md_busy", 32'(md_busy), 0);
    check("mult T+5 md_done", 32'(md_done), 0);

    // DIV followed by MFLO held valid throughout the busy window
    in_valid = 1'b1; ALUOp = 4'b1111; funct = 6'd26;
    tick();
    check("div alu_ctrl", 32'(alu_ctrl), 32'h9);
    check("div md_start", 32'(md_start), 1);
    funct = 6'd18;
    for (int k = 2; k <= 8; k++) begin
      tick();
      check($sformatf("div T+%0d in_ready", k),  32'(in_ready),  0);
      check($sformatf("div T+%0d out_valid", k), 32'(out_valid), 0);
      check($sformatf("div T+%0d md_done", k),   32'(md_done),   (k == 8) ? 1 : 0);
    end
    tick();
    check("div T+9 in_ready", 32'(in_ready), 1);
    check("div T+9 out_valid", 32'(out_valid), 0);
    tick();
    in_valid = 1'b0;
    check("mflo out_valid", 32'(out_valid), 1);
    check("mflo hilo_sel", 32'(hilo_sel), 32'h2);
    check("mflo alu_ctrl", 32'(alu_ctrl), 32'h0);
    check("mflo md_busy", 32'(md_busy), 0);
    tick();

    // DIVU aborted by reset at T+2
    in_valid = 1'b1; ALUOp = 4'b1111; funct = 6'd27;
    tick();
    in_valid = 1'b0;
    check("divu alu_ctrl", 32'(alu_ctrl), 32'h9);
    tick();
    check("divu T+2 md_busy", 32'(md_busy), 1);
    #2 reset_n = 1'b0;
    #1;
    check("abort md_busy", 32'(md_busy), 0);
    check("abort md_done", 32'(md_done), 0);
    check("abort in_ready", 32'(in_ready), 1);
    tick(); tick();
    reset_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("abort+%0d md_done", k),  32'(md_done),  0);
      check($sformatf("abort+%0d in_ready", k), 32'(in_ready), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
